philv_run_ctrl: RTL

- Parametrised, synthesizable run controller for the philosophy_v_core.
- Sequences the core's reset and clock enable, and runs the core for a bounded number of cycles.
- Halts the run on a cycle limit, a PC breakpoint or an external stop.
- Captures a per-cycle trace (PC, instruction, controller state) into a circular buffer that software or a bench reads back after the run.

---
 rtl/philv_run_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/philv_run_ctrl.sv
// -----------------------------------------------------------------------------
// philv_run_ctrl
//
// Run controller for the philosophy_v_core. It holds the core in reset for a
// fixed number of cycles, then lets it run until one of these happens: the
// cycle budget is used up, the PC reaches a breakpoint, or an external stop
// is raised. Every RUN cycle is recorded (PC, instruction, controller state)
// into a circular trace buffer. Software reads the buffer back through a
// registered port, where index 0 is the oldest valid entry.
//
// Ports
//   clk          system clock, rising edge
//   rstb         synchronous active-high reset
//   start        one-cycle pulse; starts a run from IDLE or DONE
//   stop_req     level; ends the current run
//   bp_en        breakpoint enable
//   bp_addr      breakpoint PC
//   core_pc      core's current PC
//   core_instr   core's current instruction
//   core_state   core main-controller state
//   core_en      clock enable to the core (combinational)
//   core_rstb    active-high reset to the core
//   running      high while in RUN
//   done         high while in DONE
//   done_cause   0 none, 1 cycle limit, 2 breakpoint, 3 stop
//   cycle_count  enabled core cycles in the current or last run
//   trace_count  number of valid trace entries
//   rd_idx       readback index (0 = oldest)
//   rd_pc        trace PC at rd_idx (one-cycle latency)
//   rd_instr     trace instruction at rd_idx (one-cycle latency)
//   rd_state     trace controller state at rd_idx (one-cycle latency)
// -----------------------------------------------------------------------------
module philv_run_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int INSTR_W     = 32,
    parameter int STATE_W     = 4,
    parameter int CNT_W       = 16,
    parameter int MAX_CYCLES  = 10,
    parameter int RST_CYCLES  = 2,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             rstb,
    input  logic                             start,
    input  logic                             stop_req,
    input  logic                             bp_en,
    input  logic [ADDR_W-1:0]                bp_addr,
    input  logic [ADDR_W-1:0]                core_pc,
    input  logic [INSTR_W-1:0]               core_instr,
    input  logic [STATE_W-1:0]               core_state,
    output logic                             core_en,
    output logic                             core_rstb,
    output logic                             running,
    output logic                             done,
    output logic [1:0]                       done_cause,
    output logic [CNT_W-1:0]                 cycle_count,
    output logic [$clog2(TRACE_DEPTH):0]     trace_count,
    input  logic [$clog2(TRACE_DEPTH)-1:0]   rd_idx,
    output logic [ADDR_W-1:0]                rd_pc,
    output logic [INSTR_W-1:0]               rd_instr,
    output logic [STATE_W-1:0]               rd_state
);

    localparam int PTR_W = $clog2(TRACE_DEPTH);
    localparam int TC_W  = PTR_W + 1;
    localparam int REC_W = ADDR_W + INSTR_W + STATE_W;
    localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [RC_W-1:0]  RST_LOAD   = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LIMIT_LAST = (MAX_CYCLES == 0) ? '0 : CNT_W'(MAX_CYCLES - 1);
    localparam logic [TC_W-1:0]  DEPTH_TC   = TC_W'(TRACE_DEPTH);
    localparam logic             HAS_LIMIT  = (MAX_CYCLES != 0);

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_LIMIT = 2'd1;
    localparam logic [1:0] CAUSE_BP    = 2'd2;
    localparam logic [1:0] CAUSE_STOP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RST,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_reg;
    logic [RC_W-1:0]    rst_cnt_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [REC_W-1:0]   trace_mem [TRACE_DEPTH];

    logic               bp_hit;
    logic               limit_hit;
    logic               cycle_sat;
    logic [REC_W-1:0]   rec_wr;
    logic [PTR_W-1:0]   rd_phys;
    logic               rd_valid;

    // The core is frozen on the breakpoint cycle itself, so the breakpoint
    // PC is recorded but never executed.
    assign bp_hit    = bp_en && (core_pc == bp_addr);
    assign core_en   = running && !bp_hit && !stop_req;
    assign limit_hit = HAS_LIMIT && core_en && (cycle_count == LIMIT_LAST);
    assign cycle_sat = &cycle_count;
    assign rec_wr    = {core_pc, core_instr, core_state};

    // Oldest entry sits trace_count slots behind the write pointer. When the
    // buffer is full the low bits of trace_count are zero, so the oldest
    // entry is the slot about to be overwritten.
    assign rd_phys  = wr_ptr_reg - trace_count[PTR_W-1:0] + rd_idx;
    assign rd_valid = ({1'b0, rd_idx} < trace_count);

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rstb) begin
            state_reg   <= S_IDLE;
            rst_cnt_reg <= '0;
            wr_ptr_reg  <= '0;
            core_rstb   <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            done_cause  <= CAUSE_NONE;
            cycle_count <= '0;
            trace_count <= '0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_reg   <= S_RST;
                        rst_cnt_reg <= RST_LOAD;
                        wr_ptr_reg  <= '0;
                        core_rstb   <= 1'b1;
                        done        <= 1'b0;
                        done_cause  <= CAUSE_NONE;
                        cycle_count <= '0;
                        trace_count <= '0;
                    end
                end

                S_RST: begin
                    if (rst_cnt_reg == '0) begin
                        state_reg <= S_RUN;
                        core_rstb <= 1'b0;
                        running   <= 1'b1;
                    end else begin
                        rst_cnt_reg <= rst_cnt_reg - 1'b1;
                    end
                end

                S_RUN: begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (trace_count != DEPTH_TC) begin
                        trace_count <= trace_count + 1'b1;
                    end
                    if (core_en && !cycle_sat) begin
                        cycle_count <= cycle_count + 1'b1;
                    end

                    if (stop_req) begin
                        state_reg  <= S_DONE;
                        done_cause <= CAUSE_STOP;
                        running    <= 1'b0;
                        done       <= 1'b1;
                    end else if (bp_hit) begin
                        state_reg  <= S_DONE;
                        done_cause <= CAUSE_BP;
                        running    <= 1'b0;
                        done       <= 1'b1;
                    end else if (limit_hit) begin
                        state_reg  <= S_DONE;
                        done_cause <= CAUSE_LIMIT;
                        running    <= 1'b0;
                        done       <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                    core_rstb <= 1'b1;
                    running   <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    // Trace storage: write port only, no reset, so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (!rstb && running) begin
            trace_mem[wr_ptr_reg] <= rec_wr;
        end
    end

    // Registered readback; entries beyond trace_count read as zero.
    always_ff @(posedge clk) begin
        if (rstb) begin
            rd_pc    <= '0;
            rd_instr <= '0;
            rd_state <= '0;
        end else if (rd_valid) begin
            {rd_pc, rd_instr, rd_state} <= trace_mem[rd_phys];
        end else begin
            rd_pc    <= '0;
            rd_instr <= '0;
            rd_state <= '0;
        end
    end

endmodule
